// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data-memory block (registered read port, separate write port)
// between the CPU load/store path and an external word port. The CPU has
// priority. A starvation counter forces a waiting external request through
// after STARVE_LIMIT cycles. Partial external stores use read-modify-write.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   cpu_*             CPU request (req/we/addr/wdata), stall and read-valid
//   ext_*             external request (req/we/be/addr/wdata), ack, read data
//   mem_*             memory read address/data, write enable/address/data
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [3:0]        ext_be,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ack,
  output logic [31:0]       ext_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXT_RD  = 2'd1;
  localparam logic [1:0] EXT_ACK = 2'd2;
  localparam logic [7:0] LIMIT   = 8'(STARVE_LIMIT);

  // Per-byte select: enabled bytes from the new data, the rest from memory.
  function automatic logic [31:0] byte_merge(input logic [3:0]  be,
                                             input logic [31:0] wdata,
                                             input logic [31:0] rdata);
    logic [31:0] res;
    res = rdata;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = rdata[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [7:0]        cnt_r;
  logic              ext_ack_r;
  logic [31:0]       ext_rdata_r;
  logic              cpu_rvalid_r;
  logic              lat_valid_r;
  logic              lat_we_r;
  logic [3:0]        lat_be_r;
  logic [ADDR_W-1:0] lat_addr_r;
  logic [31:0]       lat_wdata_r;
  logic              grant_ext_s;
  logic              cpu_grant_s;
  logic              we_s;

  // Grant decision, next state and memory port steering.
  always_comb begin
    grant_ext_s = 1'b0;
    cpu_grant_s = 1'b0;
    state_nxt_s = state_r;
    cpu_stall   = 1'b0;
    we_s        = 1'b0;
    mem_raddr   = cpu_addr;
    mem_waddr   = cpu_addr;
    mem_wdata   = cpu_wdata;
    case (state_r)
      IDLE: begin
        grant_ext_s = ext_req && (!cpu_req || (cnt_r == LIMIT));
        if (grant_ext_s) begin
          cpu_stall = cpu_req;
          if (ext_we && (ext_be == 4'hF)) begin
            we_s        = 1'b1;
            mem_waddr   = ext_addr;
            mem_wdata   = ext_wdata;
            state_nxt_s = EXT_ACK;
          end else if (ext_we && (ext_be == 4'h0)) begin
            state_nxt_s = EXT_ACK;
          end else begin
            mem_raddr   = ext_addr;
            state_nxt_s = EXT_RD;
          end
        end else begin
          cpu_grant_s = 1'b1;
          we_s        = cpu_req && cpu_we;
        end
      end
      EXT_RD: begin
        // CPU held off across the whole RMW so a store cannot slip in between.
        cpu_stall   = cpu_req;
        mem_raddr   = lat_addr_r;
        state_nxt_s = EXT_ACK;
        if (lat_we_r && lat_valid_r) begin
          we_s      = 1'b1;
          mem_waddr = lat_addr_r;
          mem_wdata = byte_merge(lat_be_r, lat_wdata_r, mem_rdata);
        end else begin
          we_s      = 1'b0;
        end
      end
      EXT_ACK: begin
        cpu_grant_s = 1'b1;
        we_s        = cpu_req && cpu_we;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Write strobe is suppressed while reset is held so no partial write escapes.
  assign mem_we     = we_s && !RST;
  assign ext_ack    = ext_ack_r;
  assign ext_rdata  = ext_rdata_r;
  assign cpu_rvalid = cpu_rvalid_r;

  // FSM, starvation counter, latched external request and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      ext_ack_r    <= 1'b0;
      ext_rdata_r  <= 32'd0;
      cpu_rvalid_r <= 1'b0;
      lat_valid_r  <= 1'b0;
      lat_we_r     <= 1'b0;
      lat_be_r     <= 4'd0;
      lat_addr_r   <= '0;
      lat_wdata_r  <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      ext_ack_r    <= (state_nxt_s == EXT_ACK);
      cpu_rvalid_r <= cpu_grant_s && cpu_req && !cpu_we;

      // Count consecutive cycles the external side loses to the CPU.
      if (grant_ext_s) begin
        cnt_r <= 8'd0;
      end else if (state_r == IDLE) begin
        if (ext_req && cpu_req) begin
          cnt_r <= (cnt_r == LIMIT) ? cnt_r : cnt_r + 8'd1;
        end else begin
          cnt_r <= 8'd0;
        end
      end else begin
        cnt_r <= cnt_r;
      end

      if (grant_ext_s) begin
        lat_valid_r <= 1'b1;
        lat_we_r    <= ext_we;
        lat_be_r    <= ext_be;
        lat_addr_r  <= ext_addr;
        lat_wdata_r <= ext_wdata;
      end else if (state_r == EXT_ACK) begin
        lat_valid_r <= 1'b0;
      end else begin
        lat_valid_r <= lat_valid_r;
      end

      if ((state_r == EXT_RD) && !lat_we_r) begin
        ext_rdata_r <= mem_rdata;
      end else begin
        ext_rdata_r <= ext_rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are compared at the falling edge of the same cycle.
module tb_dmem_arbiter;
  localparam int ADDR_W = 14;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [31:0]       cpu_wdata = 32'd0;
  logic              cpu_stall, cpu_rvalid;
  logic              ext_req = 1'b0, ext_we = 1'b0;
  logic [3:0]        ext_be = 4'd0;
  logic [ADDR_W-1:0] ext_addr = '0;
  logic [31:0]       ext_wdata = 32'd0;
  logic              ext_ack;
  logic [31:0]       ext_rdata;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [31:0]       mem_rdata = 32'd0, mem_wdata;
  logic              mem_we;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 CLK = ~CLK;

  // Memory block: registered read, write lands at the clock edge.
  always @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [3:0] be,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
    ext_req = req; ext_we = we; ext_be = be; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'd0;

    // Reset state
    smp();
    check("rst_ext_ack", {31'd0, ext_ack}, 32'd0);
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_ext_rdata", ext_rdata, 32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    cyc();
    RST = 1'b0;

    // Full external write, CPU idle
    set_ext(1'b1, 1'b1, 4'hF, 14'h0010, 32'hDEADBEEF);
    smp();
    check("wr_grant_we", {31'd0, mem_we}, 32'd1);
    check("wr_grant_waddr", {18'd0, mem_waddr}, 32'h10);
    check("wr_grant_wdata", mem_wdata, 32'hDEADBEEF);
    check("wr_grant_ack", {31'd0, ext_ack}, 32'd0);
    cyc();
    smp();
    check("wr_ack", {31'd0, ext_ack}, 32'd1);
    cyc();
    // External read back: ack two cycles after grant
    set_ext(1'b1, 1'b0, 4'h0, 14'h0010, 32'd0);
    smp();
    check("rd_grant_raddr", {18'd0, mem_raddr}, 32'h10);
    check("rd_grant_ack", {31'd0, ext_ack}, 32'd0);
    cyc();
    smp();
    check("rd_extrd_ack", {31'd0, ext_ack}, 32'd0);
    cyc();
    smp();
    check("rd_ack", {31'd0, ext_ack}, 32'd1);
    check("rd_data", ext_rdata, 32'hDEADBEEF);
    cyc();
    set_ext(1'b0, 1'b0, 4'h0, 14'h0, 32'd0);

    // Partial write RMW with CPU read colliding in EXT_RD
    set_cpu(1'b1, 1'b1, 14'h0020, 32'h11223344);
    smp();
    check("cpu_wr_we", {31'd0, mem_we}, 32'd1);
    check("cpu_wr_stall", {31'd0, cpu_stall}, 32'd0);
    cyc();
    set_cpu(1'b0, 1'b0, 14'h0, 32'd0);
    set_ext(1'b1, 1'b1, 4'b0101, 14'h0020, 32'hAABBCCDD);
    smp();
    check("rmw_grant_we", {31'd0, mem_we}, 32'd0);
    check("rmw_grant_raddr", {18'd0, mem_raddr}, 32'h20);
    cyc();
    set_cpu(1'b1, 1'b0, 14'h0020, 32'd0);
    smp();
    check("rmw_cpu_stall", {31'd0, cpu_stall}, 32'd1);
    check("rmw_we", {31'd0, mem_we}, 32'd1);
    check("rmw_waddr", {18'd0, mem_waddr}, 32'h20);
    check("rmw_wdata", mem_wdata, 32'h11BB33DD);
    check("rmw_no_ack", {31'd0, ext_ack}, 32'd0);
    cyc();
    smp();
    check("rmw_ack", {31'd0, ext_ack}, 32'd1);
    check("rmw_ack_stall", {31'd0, cpu_stall}, 32'd0);
    check("rmw_ack_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    cyc();
    set_ext(1'b0, 1'b0, 4'h0, 14'h0, 32'd0);
    set_cpu(1'b0, 1'b0, 14'h0, 32'd0);
    smp();
    check("rmw_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("rmw_cpu_rdata", mem_rdata, 32'h11BB33DD);
    cyc();

    // Starvation: CPU busy every cycle, external forced through at t+8
    set_cpu(1'b1, 1'b0, 14'h0001, 32'd0);
    set_ext(1'b1, 1'b1, 4'hF, 14'h0030, 32'h12345678);
    for (int k = 0; k < 8; k++) begin
      smp();
      check($sformatf("starve_stall_%0d", k), {31'd0, cpu_stall}, 32'd0);
      check($sformatf("starve_we_%0d", k), {31'd0, mem_we}, 32'd0);
      if (k == 1) check("starve_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      cyc();
    end
    smp();
    check("starve_grant_stall", {31'd0, cpu_stall}, 32'd1);
    check("starve_grant_we", {31'd0, mem_we}, 32'd1);
    check("starve_grant_waddr", {18'd0, mem_waddr}, 32'h30);
    cyc();
    smp();
    check("starve_ack", {31'd0, ext_ack}, 32'd1);
    check("starve_ack_stall", {31'd0, cpu_stall}, 32'd0);
    check("starve_ack_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    cyc();
    // Counter was cleared: a fresh request loses to the CPU again
    smp();
    check("starve_cnt_clr", {31'd0, cpu_stall}, 32'd0);
    check("starve_cnt_clr_we", {31'd0, mem_we}, 32'd0);
    cyc();
    set_ext(1'b0, 1'b0, 4'h0, 14'h0, 32'd0);
    set_cpu(1'b0, 1'b0, 14'h0, 32'd0);
    cyc();

    // Zero byte-enable write: acknowledged, nothing written
    set_cpu(1'b1, 1'b1, 14'h0040, 32'h55555555);
    cyc();
    set_cpu(1'b0, 1'b0, 14'h0, 32'd0);
    set_ext(1'b1, 1'b1, 4'h0, 14'h0040, 32'hFFFFFFFF);
    smp();
    check("be0_grant_we", {31'd0, mem_we}, 32'd0);
    cyc();
    smp();
    check("be0_ack", {31'd0, ext_ack}, 32'd1);
    check("be0_ack_we", {31'd0, mem_we}, 32'd0);
    cyc();
    set_ext(1'b0, 1'b0, 4'h0, 14'h0, 32'd0);
    set_cpu(1'b1, 1'b0, 14'h0040, 32'd0);
    cyc();
    set_cpu(1'b0, 1'b0, 14'h0, 32'd0);
    smp();
    check("be0_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("be0_word", mem_rdata, 32'h55555555);
    cyc();

    // Reset during EXT_RD of a partial write
    set_cpu(1'b1, 1'b1, 14'h0050, 32'hCAFEF00D);
    cyc();
    set_cpu(1'b0, 1'b0, 14'h0, 32'd0);
    set_ext(1'b1, 1'b1, 4'b0011, 14'h0050, 32'h00000000);
    cyc();
    RST = 1'b1;
    smp();
    check("rst_mid_we", {31'd0, mem_we}, 32'd0);
    check("rst_mid_ack", {31'd0, ext_ack}, 32'd0);
    check("rst_mid_rdata", ext_rdata, 32'd0);
    cyc();
    set_ext(1'b0, 1'b0, 4'h0, 14'h0, 32'd0);
    smp();
    check("rst_hold_ack", {31'd0, ext_ack}, 32'd0);
    cyc();
    RST = 1'b0;
    set_ext(1'b1, 1'b0, 4'h0, 14'h0050, 32'd0);
    cyc();
    cyc();
    smp();
    check("post_rst_ack", {31'd0, ext_ack}, 32'd1);
    check("post_rst_word", ext_rdata, 32'hCAFEF00D);
    cyc();
    set_ext(1'b0, 1'b0, 4'h0, 14'h0, 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
